// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared encodings for the UART TX frame controller and the downstream output mux:
// mux_sel codes, FSM state encoding and the state-to-mux_sel decode.
package uart_tx_frame_ctrl_pkg;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_SERIAL = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // IDLE and STOP both hold the line high.
  function automatic logic [1:0] mux_decode(input state_e s);
    case (s)
      ST_START:  mux_decode = MUX_START;
      ST_DATA:   mux_decode = MUX_SERIAL;
      ST_PARITY: mux_decode = MUX_PARITY;
      default:   mux_decode = MUX_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Payload handshake and mux-facing outputs of the UART TX frame controller.
interface uart_tx_frame_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  data_ack;
  logic                  busy;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  data_ack, busy, mux_sel, ser_data, par_bit
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output data_ack, busy, mux_sel, ser_data, par_bit
  );
endinterface

// File: rtl/uart_tx_frame_ctrl_parity_calc.sv
// Combinational parity of a payload: 0 = even, 1 = odd type select.
module uart_tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  typ_i,
  output logic                  par_o
);
  assign par_o = (^data_i) ^ typ_i;
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Parity support is built only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit, payload already latched
// DATA   | DATA_WIDTH payload bits, shifting right
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit; Data_Valid here chains the next frame with no idle bit
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_frame_ctrl_if.slave  bus
);

  localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  ack_q;
  logic                  busy_q;
  logic [1:0]            mux_q;
  logic                  accept;
  logic                  par_en_q;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d, par_en_d, par_calc;

  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i (bus.P_DATA),
    .typ_i  (bus.PAR_TYP),
    .par_o  (par_calc)
  );

  always_comb begin
    par_d    = par_q;
    par_en_d = par_en_q;
    if (accept) begin
      par_d    = par_calc;
      par_en_d = bus.PAR_EN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      par_q    <= par_d;
      par_en_q <= par_en_d;
    end
  end

  assign bus.par_bit = par_q;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
  assign par_en_q          = 1'b0;
  assign bus.par_bit       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
        if (bus.Data_Valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) shift_d = bus.P_DATA;
  end

  // mux_sel and busy are decoded from the next state so they change with the state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      mux_q   <= MUX_STOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ack_q   <= accept;
      busy_q  <= (state_d != ST_IDLE);
      mux_q   <= mux_decode(state_d);
    end
  end

  assign bus.data_ack = ack_q;
  assign bus.busy     = busy_q;
  assign bus.mux_sel  = mux_q;
  assign bus.ser_data = shift_q[0];

endmodule
